data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 148 ++++++++++++++
 tb/tb_data_mem.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Byte-addressed data memory with self-clearing start-up, sized loads/stores and a
// sticky misalignment flag. Define DMEM_MISALIGN_TRAP_EN to suppress misaligned stores.
module data_mem #(
  parameter int unsigned V     = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Mem_write_m,
  input  logic [V-1:0] wrdata_add,
  input  logic [V-1:0] wrdata,
  input  logic [3:0]   funct_3m,
  output logic [V-1:0] read_data,
  output logic         ready,
  output logic         misalign_err,
  output logic [15:0]  store_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  logic [V-1:0]  mem [DEPTH];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          misalign_q, misalign_d;
  logic [15:0]   count_q, count_d;

  logic [AW-1:0] idx;
  logic [V-1:0]  word_rd;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [V-1:0]  load_val;
  logic          run;
  logic          misaligned;
  logic          store_valid;
  logic          store_en;
  logic [V-1:0]  store_mask;
  logic [V-1:0]  store_data;
  logic [V-1:0]  store_word;

  // Address bits above the word index and funct_3m[3] are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wrdata_add[V-1:AW+2], funct_3m[3]};

  assign idx     = wrdata_add[AW+1:2];
  assign word_rd = mem[idx];
  assign run     = (state_q == StRun);
  assign ready   = run;

  assign ld_byte = 8'(word_rd >> {wrdata_add[1:0], 3'b000});
  assign ld_half = 16'(word_rd >> {wrdata_add[1], 4'b0000});

  always_comb begin
    load_val = word_rd;
    case (funct_3m[2:0])
      3'b000:  load_val = {{(V-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(V-16){ld_half[15]}}, ld_half};
      3'b100:  load_val = {{(V-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(V-16){1'b0}}, ld_half};
      default: load_val = word_rd;
    endcase
  end

  assign read_data = run ? load_val : '0;

  assign misaligned = ((funct_3m[1:0] == 2'b01) && wrdata_add[0]) ||
                      ((funct_3m[2:0] == 3'b010) && (wrdata_add[1:0] != 2'b00));

  // Store lanes use only the aligned address bits, so misaligned stores land on the
  // containing lane when they are allowed through.
  always_comb begin
    store_valid = 1'b1;
    store_mask  = '0;
    store_data  = '0;
    case (funct_3m[2:0])
      3'b000: begin
        store_mask = {{(V-8){1'b0}}, 8'hFF} << {wrdata_add[1:0], 3'b000};
        store_data = {{(V-8){1'b0}}, wrdata[7:0]} << {wrdata_add[1:0], 3'b000};
      end
      3'b001: begin
        store_mask = {{(V-16){1'b0}}, 16'hFFFF} << {wrdata_add[1], 4'b0000};
        store_data = {{(V-16){1'b0}}, wrdata[15:0]} << {wrdata_add[1], 4'b0000};
      end
      3'b010: begin
        store_mask = '1;
        store_data = wrdata;
      end
      default: store_valid = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign store_en = run && Mem_write_m && store_valid && !misaligned;
`else
  assign store_en = run && Mem_write_m && store_valid;
`endif

  assign store_word = (word_rd & ~store_mask) | (store_data & store_mask);

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (!run) begin
      clr_ptr_d = clr_ptr_q + AW'(1);
      if (clr_ptr_q == AW'(DEPTH - 1)) begin
        state_d = StRun;
      end
    end else begin
      if (misaligned) begin
        misalign_d = 1'b1;
      end
      if (store_en) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  // The array has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_ptr_q] <= '0;
    end else if (store_en) begin
      mem[idx] <= store_word;
    end
  end

  assign misalign_err = misalign_q;
  assign store_count  = count_q;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed vectors plus random loads/stores against a byte-array model.
module tb_data_mem;
  localparam int unsigned V     = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  f = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        misalign_err;
  logic [15:0] store_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m [NB];
  int         m_cnt;
  bit         m_mis;

  always #5 clk = ~clk;

  data_mem #(.V(V), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .Mem_write_m  (we),
    .wrdata_add   (addr),
    .wrdata       (wdata),
    .funct_3m     (f),
    .read_data    (read_data),
    .ready        (ready),
    .misalign_err (misalign_err),
    .store_count  (store_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m[i] = 8'h00;
    m_cnt = 0;
    m_mis = 1'b0;
  endtask

  function automatic int unsigned base_of(input logic [31:0] a);
    return (a % NB) & ~32'd3;
  endfunction

  function automatic bit is_mis(input logic [3:0] fc, input logic [31:0] a);
    return ((fc[1:0] == 2'b01) && a[0]) || ((fc[2:0] == 3'b010) && (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] fc, input logic [31:0] a);
    int unsigned b  = base_of(a);
    int unsigned hb = b + 2 * int'(a[1]);
    logic [7:0]  by = m[b + int'(a[1:0])];
    logic [15:0] h  = {m[hb + 1], m[hb]};
    case (fc[2:0])
      3'd0:    return {{24{by[7]}}, by};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, by};
      3'd5:    return {16'h0, h};
      default: return {m[b + 3], m[b + 2], m[b + 1], m[b]};
    endcase
  endfunction

  task automatic model_store(input logic [3:0] fc, input logic [31:0] a, input logic [31:0] d);
    int unsigned b  = base_of(a);
    int unsigned hb = b + 2 * int'(a[1]);
    bit trap = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = is_mis(fc, a);
`endif
    if (!trap) begin
      case (fc[2:0])
        3'd0: begin m[b + int'(a[1:0])] = d[7:0]; m_cnt++; end
        3'd1: begin m[hb] = d[7:0]; m[hb + 1] = d[15:8]; m_cnt++; end
        3'd2: begin
          for (int k = 0; k < 4; k++) m[b + k] = d[8*k +: 8];
          m_cnt++;
        end
        default: ;
      endcase
    end
  endtask

  // One access: check the combinational load, clock it, then check the sticky state.
  task automatic op(input string tag, input bit w, input logic [3:0] fc, input logic [31:0] a,
                    input logic [31:0] d, input bit use_exp = 1'b0,
                    input logic [31:0] exp = '0);
    we = w; f = fc; addr = a; wdata = d;
    #1;
    check({tag, ":rd"}, read_data, model_load(fc, a));
    if (use_exp) check({tag, ":lit"}, read_data, exp);
    @(posedge clk);
    if (is_mis(fc, a)) m_mis = 1'b1;
    if (w) model_store(fc, a, d);
    #1;
    check({tag, ":mis"}, {31'h0, misalign_err}, {31'h0, m_mis});
    check({tag, ":cnt"}, {16'h0, store_count}, 32'(m_cnt & 32'hFFFF));
    we = 1'b0; f = 4'h0;
  endtask

  task automatic wait_clear(input string tag);
    int cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready) break;
      if (cyc == 100) check({tag, ":clr_rd"}, read_data, 32'h0);
    end
    check({tag, ":clr_len"}, 32'(cyc), 32'(DEPTH));
  endtask

  initial begin
    model_reset();
    #3 reset = 1'b0;
    #9;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rd", read_data, 32'h0);
    check("rst_cnt", {16'h0, store_count}, 32'h0);
    check("rst_mis", {31'h0, misalign_err}, 32'h0);

    // Release reset with a store held asserted: it must be ignored throughout CLEAR.
    @(negedge clk);
    reset = 1'b1; we = 1'b1; f = 4'h2; addr = 32'h40; wdata = 32'hDEADBEEF;
    wait_clear("init");
    we = 1'b0; f = 4'h0;
    check("clr_cnt", {16'h0, store_count}, 32'h0);
    op("lw40", 1'b0, 4'h2, 32'h40, 32'h0, 1'b1, 32'h0);
    op("lw3fc", 1'b0, 4'h2, 32'h3FC, 32'h0, 1'b1, 32'h0);

    op("sw10", 1'b1, 4'h2, 32'h10, 32'h80FF7F01);
    op("lb10", 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 32'h00000001);
    op("lb13", 1'b0, 4'h0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80);
    op("lbu13", 1'b0, 4'h4, 32'h13, 32'h0, 1'b1, 32'h00000080);
    op("lh12", 1'b0, 4'h1, 32'h12, 32'h0, 1'b1, 32'hFFFF80FF);
    op("lhu12", 1'b0, 4'h5, 32'h12, 32'h0, 1'b1, 32'h000080FF);
    check("cnt1", {16'h0, store_count}, 32'h1);

    op("sw20", 1'b1, 4'h2, 32'h20, 32'h11223344);
    op("sb21", 1'b1, 4'h0, 32'h21, 32'h000000AA);
    op("lw20", 1'b0, 4'h2, 32'h20, 32'h0, 1'b1, 32'h1122AA44);

    op("sw30", 1'b1, 4'h2, 32'h30, 32'hCAFEF00D);
    check("mis_pre", {31'h0, misalign_err}, 32'h0);
    op("sh31", 1'b1, 4'h1, 32'h31, 32'h00001234);
    check("mis_set", {31'h0, misalign_err}, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
    op("lw30", 1'b0, 4'h2, 32'h30, 32'h0, 1'b1, 32'hCAFEF00D);
    check("cnt_sh31", {16'h0, store_count}, 32'h4);
`else
    op("lw30", 1'b0, 4'h2, 32'h30, 32'h0, 1'b1, 32'hCAFE1234);
    check("cnt_sh31", {16'h0, store_count}, 32'h5);
`endif

    op("sw_wrap", 1'b1, 4'h2, NB + 32'h8, 32'h5A5A1234);
    op("lw8", 1'b0, 4'h2, 32'h8, 32'h0, 1'b1, 32'h5A5A1234);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  fc;
      logic [31:0] a;
      fc = 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 2 * NB - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (fc[1:0] == 2'b01) a[0] = 1'b0;
        if (fc[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      op("rnd", 1'($urandom_range(0, 1)), fc, a, $urandom());
    end

    // Drive store_count up to its wrap point with back-to-back word stores.
    we = 1'b1; f = 4'h2; addr = 32'h0; wdata = 32'h01020304;
    while ((m_cnt & 32'hFFFF) != 32'hFFFF) begin
      @(posedge clk);
      model_store(4'h2, 32'h0, 32'h01020304);
    end
    #1;
    we = 1'b0; f = 4'h0;
    check("cnt_max", {16'h0, store_count}, 32'hFFFF);
    op("sw_cwrap", 1'b1, 4'h2, 32'h4, 32'h0BADF00D);
    check("cnt_wrap", {16'h0, store_count}, 32'h0);

    // Mid-stream reset with non-trivial sticky state.
    reset = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    wait_clear("rst2");
    for (int i = 0; i < 5; i++) op("sw5", 1'b1, 4'h2, 32'(i * 4 + 32'h60), $urandom());
    op("lh1", 1'b0, 4'h1, 32'h1, 32'h0);
    check("pre_cnt5", {16'h0, store_count}, 32'h5);
    check("pre_mis1", {31'h0, misalign_err}, 32'h1);
    we = 1'b1; f = 4'h2; addr = 32'h50; wdata = 32'h77;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_cnt", {16'h0, store_count}, 32'h0);
    check("mid_mis", {31'h0, misalign_err}, 32'h0);
    check("mid_ready", {31'h0, ready}, 32'h0);
    check("mid_rd", read_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; we = 1'b0; f = 4'h0;
    wait_clear("rst3");
    op("lw50", 1'b0, 4'h2, 32'h50, 32'h0, 1'b1, 32'h0);
    op("lw60", 1'b0, 4'h2, 32'h60, 32'h0, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
